// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer. The fetch stage looks up each PC
//   combinationally, with no latency. The branch unit writes resolved
//   branches and jumps back into the table. A two-state FSM invalidates the
//   whole table by clearing one entry per cycle.
//
// Parameters
//   PC_W     program counter / target width in bits
//   ENTRIES  number of entries (power of two, >= 4)
//
// Ports
//   Clk           clock, rising edge
//   Rst_n         asynchronous active-low reset
//   FetchPc       PC to look up
//   PcMatchValid  lookup hit a valid entry with a matching tag
//   PredTarget    target of the hit entry (0 on miss)
//   CtrlState     2-bit control code of the hit entry (0 on miss)
//   PredictTaken  redirect fetch (hit and (IsJump or Ctrl[1]))
//   UpdWe         update strobe from the branch unit
//   UpdPc         PC of the resolved branch/jump
//   UpdTarget     resolved target
//   UpdCtrl       new 2-bit control code
//   UpdIsJump     resolved instruction is an unconditional jump
//   InvReq        invalidate-all request
//   Busy          invalidation sweep in progress
// ---------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [PC_W-1:0] FetchPc,
  output logic            PcMatchValid,
  output logic [PC_W-1:0] PredTarget,
  output logic [1:0]      CtrlState,
  output logic            PredictTaken,
  input  logic            UpdWe,
  input  logic [PC_W-1:0] UpdPc,
  input  logic [PC_W-1:0] UpdTarget,
  input  logic [1:0]      UpdCtrl,
  input  logic            UpdIsJump,
  input  logic            InvReq,
  output logic            Busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_cnt;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctrl   [ENTRIES];
  logic [ENTRIES-1:0] r_isjump;

  logic               w_busy;
  logic               w_upd_en;
  logic [IDX_W-1:0]   w_fetch_idx;
  logic [TAG_W-1:0]   w_fetch_tag;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_hit;
  logic               w_unused_lsbs;

  // PC[1:0] carry no information for the table (word-aligned instructions).
  assign w_unused_lsbs = ^{FetchPc[1:0], UpdPc[1:0]};

  assign w_fetch_idx = FetchPc[IDX_W+1:2];
  assign w_fetch_tag = FetchPc[PC_W-1:IDX_W+2];
  assign w_upd_idx   = UpdPc[IDX_W+1:2];
  assign w_upd_tag   = UpdPc[PC_W-1:IDX_W+2];

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (InvReq) w_state_nxt = SWEEP;
      SWEEP:   if (r_cnt == IDX_W'(ENTRIES - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy   = (r_state == SWEEP);
    w_upd_en = UpdWe & ~w_busy;
  end

  assign Busy = w_busy;

  // Sweep counter: wraps from ENTRIES-1 to 0 on the same edge that leaves
  // SWEEP, so it is already 0 for the next sweep.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Table storage. Updates are blocked while sweeping, so the write port
  // and the sweep clear never target the same entry in one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid  <= '0;
      r_isjump <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctrl[i]   <= '0;
      end
    end else begin
      if (w_upd_en) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= UpdTarget;
        r_ctrl[w_upd_idx]   <= UpdCtrl;
        r_isjump[w_upd_idx] <= UpdIsJump;
      end
      if (w_busy) begin
        r_valid[r_cnt] <= 1'b0;
      end
    end
  end

  // Lookup reads registered state only, so a same-cycle update is seen
  // from the next cycle on.
  always_comb begin
    w_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag) && !w_busy;
    PcMatchValid = w_hit;
    PredTarget   = w_hit ? r_target[w_fetch_idx] : '0;
    CtrlState    = w_hit ? r_ctrl[w_fetch_idx] : 2'b00;
    PredictTaken = w_hit & (r_isjump[w_fetch_idx] | r_ctrl[w_fetch_idx][1]);
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//   Self-checking bench for branch_target_buffer (PC_W=32, ENTRIES=16).
//   Inputs change on the falling edge; outputs are checked 2 time units
//   later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  localparam int PC_W    = 32;
  localparam int ENTRIES = 16;

  logic            Clk;
  logic            Rst_n;
  logic [PC_W-1:0] FetchPc;
  logic            PcMatchValid;
  logic [PC_W-1:0] PredTarget;
  logic [1:0]      CtrlState;
  logic            PredictTaken;
  logic            UpdWe;
  logic [PC_W-1:0] UpdPc;
  logic [PC_W-1:0] UpdTarget;
  logic [1:0]      UpdCtrl;
  logic            UpdIsJump;
  logic            InvReq;
  logic            Busy;

  branch_target_buffer #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .FetchPc      (FetchPc),
    .PcMatchValid (PcMatchValid),
    .PredTarget   (PredTarget),
    .CtrlState    (CtrlState),
    .PredictTaken (PredictTaken),
    .UpdWe        (UpdWe),
    .UpdPc        (UpdPc),
    .UpdTarget    (UpdTarget),
    .UpdCtrl      (UpdCtrl),
    .UpdIsJump    (UpdIsJump),
    .InvReq       (InvReq),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic            hit;
    logic [PC_W-1:0] tgt;
    logic [1:0]      ctrl;
    logic            taken;
    logic            busy;
  } exp_t;

  typedef struct packed {
    logic [PC_W-1:0] fetch;
    logic            we;
    logic [PC_W-1:0] upc;
    logic [PC_W-1:0] utgt;
    logic [1:0]      uctrl;
    logic            ujmp;
    logic            inv;
    exp_t            e;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t miss(input logic busy);
    exp_t e;
    e = '{hit: 1'b0, tgt: '0, ctrl: 2'b00, taken: 1'b0, busy: busy};
    return e;
  endfunction

  function automatic exp_t hitv(input logic [PC_W-1:0] tgt, input logic [1:0] ctrl,
                                input logic taken);
    exp_t e;
    e = '{hit: 1'b1, tgt: tgt, ctrl: ctrl, taken: taken, busy: 1'b0};
    return e;
  endfunction

  function automatic vec_t mk(input logic [PC_W-1:0] fetch, input logic we,
                              input logic [PC_W-1:0] upc, input logic [PC_W-1:0] utgt,
                              input logic [1:0] uctrl, input logic ujmp, input logic inv,
                              input exp_t e);
    vec_t v;
    v = '{fetch: fetch, we: we, upc: upc, utgt: utgt, uctrl: uctrl, ujmp: ujmp,
          inv: inv, e: e};
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check(input string name);
    exp_t e;
    exp_t a;
    #2;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      a = '{hit: PcMatchValid, tgt: PredTarget, ctrl: CtrlState, taken: PredictTaken,
            busy: Busy};
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%b tgt=%h ctrl=%b taken=%b busy=%b, expected hit=%b tgt=%h ctrl=%b taken=%b busy=%b",
                 name, a.hit, a.tgt, a.ctrl, a.taken, a.busy,
                 e.hit, e.tgt, e.ctrl, e.taken, e.busy);
      end
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, queue its expectation,
  // then compare before the next rising edge commits the update.
  task automatic step(input vec_t v, input string name);
    @(negedge Clk);
    FetchPc   = v.fetch;
    UpdWe     = v.we;
    UpdPc     = v.upc;
    UpdTarget = v.utgt;
    UpdCtrl   = v.uctrl;
    UpdIsJump = v.ujmp;
    InvReq    = v.inv;
    sb_q.push_back(v.e);
    check(name);
  endtask

  task automatic look(input logic [PC_W-1:0] pc, input exp_t e, input string name);
    step(mk(pc, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, e), name);
  endtask

  vec_t vt[13];

  initial begin
    Rst_n     = 1'b0;
    FetchPc   = '0;
    UpdWe     = 1'b0;
    UpdPc     = '0;
    UpdTarget = '0;
    UpdCtrl   = 2'b00;
    UpdIsJump = 1'b0;
    InvReq    = 1'b0;

    // Reset state, including an update attempt held off by reset.
    step(mk(32'h100, 1'b1, 32'h100, 32'h999, 2'b11, 1'b1, 1'b1, miss(1'b0)), "in_reset");
    look(32'h100, miss(1'b0), "in_reset_no_write");
    @(negedge Clk);
    Rst_n = 1'b1;

    // Lookup/update vectors. Index = PC[5:2]; 0x100 and 0x140 share index 0.
    vt[0]  = mk(32'h100, 0, 32'h0,   32'h0,   2'b00, 0, 0, miss(0));
    vt[1]  = mk(32'h100, 1, 32'h100, 32'h240, 2'b10, 0, 0, miss(0));
    vt[2]  = mk(32'h100, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h240, 2'b10, 1));
    vt[3]  = mk(32'h102, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h240, 2'b10, 1));
    vt[4]  = mk(32'h100, 1, 32'h100, 32'h240, 2'b01, 0, 0, hitv(32'h240, 2'b10, 1));
    vt[5]  = mk(32'h100, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h240, 2'b01, 0));
    vt[6]  = mk(32'h100, 1, 32'h104, 32'h800, 2'b00, 1, 0, hitv(32'h240, 2'b01, 0));
    vt[7]  = mk(32'h104, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h800, 2'b00, 1));
    vt[8]  = mk(32'h140, 1, 32'h140, 32'h300, 2'b11, 0, 0, miss(0));
    vt[9]  = mk(32'h100, 0, 32'h0,   32'h0,   2'b00, 0, 0, miss(0));
    vt[10] = mk(32'h140, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h300, 2'b11, 1));
    vt[11] = mk(32'h104, 0, 32'h0,   32'h0,   2'b00, 0, 0, hitv(32'h800, 2'b00, 1));
    vt[12] = mk(32'h1104, 0, 32'h0,  32'h0,   2'b00, 0, 0, miss(0));
    for (int i = 0; i < 13; i++) begin
      step(vt[i], $sformatf("vec%0d", i));
    end

    // Fill entries 0..3, then sweep. Entry 0 holds 0x140, so 0x200 misses first.
    for (int i = 0; i < 4; i++) begin
      step(mk(32'h200, 1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(16 * i), 2'b11, 0, 0,
              (i == 0) ? miss(0) : hitv(32'h1000, 2'b11, 1)),
           $sformatf("fill%0d", i));
    end
    // InvReq together with an update: update lands, then the sweep clears it.
    step(mk(32'h20C, 1, 32'h210, 32'h2000, 2'b01, 0, 1, hitv(32'h1030, 2'b11, 1)),
         "inv_pulse");
    // Exactly ENTRIES busy cycles; InvReq and an update to already-swept
    // index 1 (0x3C4) arrive mid-sweep and must be dropped.
    for (int i = 0; i < ENTRIES; i++) begin
      step(mk(32'h20C, (i == 10), 32'h3C4, 32'h3000, 2'b11, 1, (i == 5), miss(1)),
           $sformatf("sweep%0d", i));
    end
    look(32'h204, miss(0), "sweep_done");
    look(32'h200, miss(0), "post_sweep_200");
    look(32'h208, miss(0), "post_sweep_208");
    look(32'h20C, miss(0), "post_sweep_20C");
    look(32'h210, miss(0), "post_sweep_210");
    look(32'h3C4, miss(0), "dropped_upd_3C4");
    look(32'h104, miss(0), "post_sweep_104");

    // Reset in the middle of a sweep. Fill indices 8..11 first.
    for (int i = 0; i < 4; i++) begin
      step(mk(32'h220 + 32'(4 * i), 1, 32'h220 + 32'(4 * i), 32'h4000 + 32'(16 * i),
              2'b10, 0, 0, miss(0)),
           $sformatf("fill_b%0d", i));
    end
    step(mk(32'h220, 0, 32'h0, 32'h0, 2'b00, 0, 1, hitv(32'h4000, 2'b10, 1)), "inv_pulse_b");
    for (int i = 0; i < 5; i++) begin
      look(32'h224, miss(1), $sformatf("sweep_b%0d", i));
    end
    @(negedge Clk);
    Rst_n   = 1'b0;
    FetchPc = 32'h224;
    sb_q.push_back(miss(0));
    check("rst_mid_sweep");
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      look(32'h220 + 32'(4 * i), miss(0), $sformatf("after_rst%0d", i));
    end
    // Normal operation resumes.
    step(mk(32'h230, 1, 32'h230, 32'h5000, 2'b00, 1, 0, miss(0)), "resume_upd");
    look(32'h230, hitv(32'h5000, 2'b00, 1), "resume_hit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter PC_W, default 32: program counter and target width in bits.
REQ-002 The block SHALL have parameter ENTRIES, default 16: number of direct-mapped entries, a power of two, at least 4.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port FetchPc, input, PC_W bits: fetch-stage PC to look up.
REQ-006 The block SHALL have port PcMatchValid, output, 1 bit: FetchPc hits a valid entry with a matching tag.
REQ-007 The block SHALL have port PredTarget, output, PC_W bits: stored target of the hit entry.
REQ-008 The block SHALL have port CtrlState, output, 2 bits: stored 2-bit control code of the hit entry, fed to the branch unit's CtrlIn.
REQ-009 The block SHALL have port PredictTaken, output, 1 bit: fetch redirect request.
REQ-010 The block SHALL have port UpdWe, input, 1 bit: update strobe, driven by the branch unit's WriteEnable.
REQ-011 The block SHALL have port UpdPc, input, PC_W bits: PC of the resolved branch or jump.
REQ-012 The block SHALL have port UpdTarget, input, PC_W bits: resolved target address.
REQ-013 The block SHALL have port UpdCtrl, input, 2 bits: new control code, driven by the branch unit's CtrlOut.
REQ-014 The block SHALL have port UpdIsJump, input, 1 bit: the resolved instruction is an unconditional jump.
REQ-015 The block SHALL have port InvReq, input, 1 bit: request to invalidate the whole table.
REQ-016 The block SHALL have port Busy, output, 1 bit: invalidation sweep in progress.

Function
REQ-017 Index SHALL be PC[IDX_W+1:2], where IDX_W = log2(ENTRIES); tag SHALL be PC[PC_W-1:IDX_W+2]; PC[1:0] SHALL be ignored.
REQ-018 Each entry SHALL hold Valid, Tag, Target (PC_W bits), Ctrl (2 bits) and IsJump.
REQ-019 Lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-020 PcMatchValid SHALL equal entry Valid AND (entry Tag == FetchPc tag), and SHALL be forced to 0 while Busy = 1.
REQ-021 On a miss, PredTarget SHALL be 0, CtrlState SHALL be 2'b00 and PredictTaken SHALL be 0.
REQ-022 On a hit, PredictTaken SHALL equal IsJump OR Ctrl[1].
REQ-023 On a rising edge with UpdWe = 1 and Busy = 0, the entry at the UpdPc index SHALL be written with Valid = 1, the UpdPc tag, UpdTarget, UpdCtrl and UpdIsJump, overwriting any previous occupant (no tag check).
REQ-024 A lookup and an update to the same index in the same cycle SHALL return the pre-update contents; the new contents SHALL be visible from the next cycle.
REQ-025 The FSM SHALL have two states, IDLE and SWEEP.
REQ-026 In IDLE, InvReq = 1 SHALL move the FSM to SWEEP on the next edge with sweep counter = 0, and Busy SHALL be 1 from that edge.
REQ-027 In SWEEP, each cycle SHALL clear Valid of entry[counter] and increment the counter.
REQ-028 After clearing entry ENTRIES-1, the FSM SHALL return to IDLE; Busy SHALL be high for exactly ENTRIES cycles.
REQ-029 UpdWe and InvReq SHALL be ignored while Busy = 1, with no queueing.
REQ-030 If InvReq and UpdWe are both 1 in IDLE, the update SHALL be performed and the sweep SHALL then start; the updated entry is cleared by the sweep.
REQ-031 The sweep counter SHALL be IDX_W bits wide, and wrap from ENTRIES-1 SHALL coincide with the exit to IDLE.

Reset
REQ-032 While Rst_n = 0, all Valid bits SHALL be 0, the FSM SHALL be IDLE, the counter SHALL be 0 and Busy SHALL be 0; PcMatchValid and PredictTaken SHALL therefore be 0.
REQ-033 Target, Tag, Ctrl and IsJump SHALL be reset to 0.
REQ-034 Assertion of reset mid-sweep SHALL abort the sweep immediately, with the state given in REQ-032.
REQ-035 Operation SHALL resume on the first rising edge after Rst_n deasserts.

Verification
REQ-036 Scenario: reset, then FetchPc = 0x100 -> PcMatchValid = 0, PredTarget = 0, PredictTaken = 0.
REQ-037 Scenario: update UpdPc = 0x100, UpdTarget = 0x240, UpdCtrl = 2'b10, UpdIsJump = 0; next cycle FetchPc = 0x100 -> PcMatchValid = 1, PredTarget = 0x240, CtrlState = 2'b10, PredictTaken = 1.
REQ-038 Scenario: alias at the same index, UpdPc = 0x140 (ENTRIES = 16) -> FetchPc = 0x100 misses and FetchPc = 0x140 hits.
REQ-039 Scenario: same-cycle update and lookup at 0x100 with UpdCtrl = 2'b01 -> that cycle returns CtrlState = 2'b10, the next cycle returns 2'b01.
REQ-040 Scenario: fill 4 entries, pulse InvReq -> Busy = 1 for 16 cycles; an UpdWe issued during the sweep is dropped; afterwards all lookups miss.
REQ-041 Scenario: Rst_n low at sweep cycle 5 -> Busy = 0 immediately and all lookups miss after release.
